// File: rtl/lieat_lsu_membridge_if.sv
// rtl/lieat_lsu_membridge_if.sv - LSU request/response and memory-bus channels of the LSU memory bridge
interface lieat_lsu_membridge_if;
  // LSU request channel
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_req_ren;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_addr;
  logic [2:0]  lsu_req_flag;
  logic [31:0] lsu_req_wdata;
  logic        lsu_req_fencei;
  // LSU response channel
  logic        lsu_rsp_valid;
  logic        lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata;
  logic        lsu_rsp_err;
  // memory-bus request channel
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  // memory-bus response channel
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  // bridge view
  modport slave (
    input  lsu_req_valid, lsu_req_ren, lsu_req_wen, lsu_req_addr,
    input  lsu_req_flag, lsu_req_wdata, lsu_req_fencei,
    output lsu_req_ready,
    output lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    input  lsu_rsp_ready,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    output mem_rsp_ready
  );

  // LSU plus memory view
  modport master (
    output lsu_req_valid, lsu_req_ren, lsu_req_wen, lsu_req_addr,
    output lsu_req_flag, lsu_req_wdata, lsu_req_fencei,
    input  lsu_req_ready,
    input  lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    output lsu_rsp_ready,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_rdata, mem_rsp_err,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/lieat_lsu_membridge.sv
// rtl/lieat_lsu_membridge.sv - single-outstanding LSU to word-bus bridge; optional LIEAT_LSU_MISALIGN_CHK_EN alignment check
module lieat_lsu_membridge #(
  parameter int XLEN = 32
) (
  input logic                  clk,
  input logic                  rstn,
  lieat_lsu_membridge_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      flag_q, flag_d;
  logic            wen_q, wen_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] fmt_wdata;
  logic [3:0]      fmt_wstrb;
  logic [XLEN-1:0] fmt_rdata;
  logic [15:0]     rd_sh;

`ifdef LIEAT_LSU_MISALIGN_CHK_EN
  logic            req_misal;

  // half needs an even address, word needs a word-aligned address
  assign req_misal = ((bus.lsu_req_flag[1:0] == 2'b01) && bus.lsu_req_addr[0]) ||
                     (bus.lsu_req_flag[1] && (bus.lsu_req_addr[1:0] != 2'b00));
`endif

  // replicate store data onto every lane and pick the lanes to write
  always_comb begin
    fmt_wdata = wdata_q;
    fmt_wstrb = 4'b1111;
    case (flag_q[1:0])
      2'b00: begin
        fmt_wdata = {4{wdata_q[7:0]}};
        fmt_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{wdata_q[15:0]}};
        fmt_wstrb = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
      end
    endcase
  end

  // only the low half of the lane-shifted word can ever reach the LSU
  assign rd_sh = 16'(bus.mem_rsp_rdata >> {addr_q[1:0], 3'b000});

  // right-justify and extend returned load data
  always_comb begin
    case (flag_q[1:0])
      2'b00:   fmt_rdata = {{24{~flag_q[2] & rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   fmt_rdata = {{16{~flag_q[2] & rd_sh[15]}}, rd_sh[15:0]};
      default: fmt_rdata = bus.mem_rsp_rdata;
    endcase
  end

  // state and captured request/response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      flag_q  <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      flag_q  <= flag_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
    end
  end

  // next state; ren and fencei only steer the IDLE decision so they are not kept
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    flag_d  = flag_q;
    wen_d   = wen_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.lsu_req_valid) begin
          addr_d  = bus.lsu_req_addr;
          wdata_d = bus.lsu_req_wdata;
          flag_d  = bus.lsu_req_flag;
          wen_d   = bus.lsu_req_wen;
          rdata_d = '0;
          err_d   = 1'b0;
          if (bus.lsu_req_fencei || (!bus.lsu_req_ren && !bus.lsu_req_wen)) begin
            state_d = S_RSP;
          end
`ifdef LIEAT_LSU_MISALIGN_CHK_EN
          else if (req_misal) begin
            err_d   = 1'b1;
            state_d = S_RSP;
          end
`endif
          else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          rdata_d = wen_q ? '0 : fmt_rdata;
          err_d   = bus.mem_rsp_err;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.lsu_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.lsu_req_ready = (state_q == S_IDLE);
  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_req_wen   = wen_q;
  assign bus.mem_req_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign bus.mem_req_wdata = fmt_wdata;
  assign bus.mem_req_wstrb = wen_q ? fmt_wstrb : 4'b0000;
  assign bus.mem_rsp_ready = (state_q == S_WAIT);
  assign bus.lsu_rsp_valid = (state_q == S_RSP);
  assign bus.lsu_rsp_rdata = rdata_q;
  assign bus.lsu_rsp_err   = err_q;

endmodule

// File: tb/tb_lieat_lsu_membridge.sv
// tb/tb_lieat_lsu_membridge.sv - self-checking bench for the LSU memory bridge
module tb_lieat_lsu_membridge;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  lieat_lsu_membridge_if bus ();

  lieat_lsu_membridge #(.XLEN(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  localparam logic [31:0] SENT = 32'h5A5A_A5A5;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  // expected transaction from the model
  logic        exp_bus;
  logic [31:0] exp_maddr, exp_wdata, exp_rdata;
  logic [3:0]  exp_strb;
  logic        exp_wen, exp_err;

  // last values seen on the DUT outputs
  logic [31:0] last_rdata, last_maddr, last_wdata;
  logic [3:0]  last_strb;
  logic        last_err, last_mwen;

  int req_first, rsp_first, req_cnt, rsp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // behavioural model: what the bus request and LSU response must look like
  task automatic model_set(input logic ren, input logic wen, input logic fence,
                           input logic [31:0] addr, input logic [2:0] flag,
                           input logic [31:0] wdata, input logic [31:0] brdata,
                           input logic berr);
    logic [1:0]  o;
    logic [1:0]  size;
    logic        usign, misal, noop;
    logic [31:0] v;
    o     = addr[1:0];
    size  = flag[1:0];
    usign = flag[2];
    misal = 1'b0;
`ifdef LIEAT_LSU_MISALIGN_CHK_EN
    misal = ((size == 2'd1) && addr[0]) || ((size >= 2'd2) && (o != 2'd0));
`endif
    noop      = fence || (!ren && !wen);
    exp_bus   = !noop && !misal;
    exp_maddr = addr - 32'(o);
    exp_wen   = wen;
    if (size == 2'd0) begin
      exp_wdata = (wdata % 256) * 32'h0101_0101;
      exp_strb  = 4'(1 << o);
    end else if (size == 2'd1) begin
      exp_wdata = (wdata % 65536) * 32'h0001_0001;
      exp_strb  = (o >= 2'd2) ? 4'hC : 4'h3;
    end else begin
      exp_wdata = wdata;
      exp_strb  = 4'hF;
    end
    if (!wen) exp_strb = 4'h0;
    v = brdata >> (8 * o);
    if (size == 2'd0) begin
      v = v % 256;
      if (!usign && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = v % 65536;
      if (!usign && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = brdata;
    end
    exp_rdata = (noop || misal || wen) ? 32'h0 : v;
    exp_err   = misal ? 1'b1 : (noop ? 1'b0 : berr);
  endtask

  // compare process: every cycle the outputs carry a transaction
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rstn && mon_en) begin
        if (bus.mem_req_valid) begin
          last_maddr = bus.mem_req_addr;
          last_wdata = bus.mem_req_wdata;
          last_strb  = bus.mem_req_wstrb;
          last_mwen  = bus.mem_req_wen;
          if (!exp_bus) begin
            check("unexpected_mem_req", 32'(bus.mem_req_valid), 32'h0);
          end else begin
            check("mem_req_addr", bus.mem_req_addr, exp_maddr);
            check("mem_req_wen", 32'(bus.mem_req_wen), 32'(exp_wen));
            check("mem_req_wstrb", 32'(bus.mem_req_wstrb), 32'(exp_strb));
            if (exp_wen) check("mem_req_wdata", bus.mem_req_wdata, exp_wdata);
          end
        end
        if (bus.lsu_rsp_valid) begin
          last_rdata = bus.lsu_rsp_rdata;
          last_err   = bus.lsu_rsp_err;
          check("lsu_rsp_rdata", bus.lsu_rsp_rdata, exp_rdata);
          check("lsu_rsp_err", 32'(bus.lsu_rsp_err), 32'(exp_err));
        end
      end
    end
  endtask

  // one full transaction; starts and ends just after a rising edge
  task automatic run_tx(input string tag, input logic ren, input logic wen, input logic fence,
                        input logic [31:0] addr, input logic [2:0] flag, input logic [31:0] wdata,
                        input logic [31:0] brdata, input logic berr,
                        input int req_stall, input int rsp_stall);
    int  c;
    logic done;
    model_set(ren, wen, fence, addr, flag, wdata, brdata, berr);
    last_rdata = SENT; last_maddr = SENT; last_wdata = SENT;
    last_strb = 4'h7; last_err = 1'bx; last_mwen = 1'bx;
    req_first = 0; rsp_first = 0; req_cnt = 0; rsp_cnt = 0;
    bus.lsu_req_valid  = 1'b1;
    bus.lsu_req_ren    = ren;
    bus.lsu_req_wen    = wen;
    bus.lsu_req_fencei = fence;
    bus.lsu_req_addr   = addr;
    bus.lsu_req_flag   = flag;
    bus.lsu_req_wdata  = wdata;
    bus.mem_req_ready  = (req_stall == 0);
    bus.mem_rsp_valid  = 1'b1;
    bus.mem_rsp_rdata  = brdata;
    bus.mem_rsp_err    = berr;
    bus.lsu_rsp_ready  = (rsp_stall == 0);
    @(negedge clk);
    check({tag, "_accept_ready"}, 32'(bus.lsu_req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.lsu_req_valid = 1'b0;
    done = 1'b0;
    c = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      check({tag, "_busy_ready"}, 32'(bus.lsu_req_ready), 32'h0);
      if (bus.mem_req_valid) begin
        req_cnt++;
        if (req_first == 0) req_first = c;
      end
      if (bus.lsu_rsp_valid) begin
        rsp_cnt++;
        if (rsp_first == 0) rsp_first = c;
        if (bus.lsu_rsp_ready) done = 1'b1;
      end
      if (!done) begin
        @(posedge clk);
        #1;
        bus.mem_req_ready = (req_cnt >= req_stall);
        bus.lsu_rsp_ready = (rsp_cnt >= rsp_stall);
      end
    end
    check({tag, "_done"}, 32'(done), 32'h1);
    check({tag, "_req_first"}, 32'(req_first), exp_bus ? 32'd1 : 32'd0);
    check({tag, "_req_cycles"}, 32'(req_cnt), exp_bus ? 32'(req_stall + 1) : 32'd0);
    check({tag, "_rsp_latency"}, 32'(rsp_first), exp_bus ? 32'(3 + req_stall) : 32'd1);
    check({tag, "_rsp_cycles"}, 32'(rsp_cnt), 32'(rsp_stall + 1));
    @(posedge clk);
    #1;
    bus.lsu_rsp_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(bus.lsu_req_ready), 32'h1);
    check({tag, "_rsp_dropped"}, 32'(bus.lsu_rsp_valid), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lsu_req_valid = 1'b0; bus.lsu_req_ren = 1'b0; bus.lsu_req_wen = 1'b0;
    bus.lsu_req_fencei = 1'b0; bus.lsu_req_addr = '0; bus.lsu_req_flag = '0;
    bus.lsu_req_wdata = '0; bus.lsu_rsp_ready = 1'b0; bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0; bus.mem_rsp_err = 1'b0;
    exp_bus = 1'b0; exp_maddr = '0; exp_wdata = '0; exp_rdata = '0;
    exp_strb = '0; exp_wen = 1'b0; exp_err = 1'b0;
    fork
      monitor();
    join_none

    // reset state
    #12;
    check("rst_lsu_rsp_valid", 32'(bus.lsu_rsp_valid), 32'h0);
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'h0);
    check("rst_mem_rsp_ready", 32'(bus.mem_rsp_ready), 32'h0);
    check("rst_lsu_req_ready", 32'(bus.lsu_req_ready), 32'h1);
    check("rst_lsu_rsp_rdata", bus.lsu_rsp_rdata, 32'h0);
    check("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
    check("rst_mem_req_wstrb", 32'(bus.mem_req_wstrb), 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    mon_en = 1'b1;

    run_tx("lb", 1, 0, 0, 32'h8000_0003, 3'b000, 32'h0, 32'h80AB_CDEF, 0, 0, 0);
    check("lb_rdata", last_rdata, 32'hFFFF_FF80);
    check("lb_addr", last_maddr, 32'h8000_0000);
    check("lb_strb", 32'(last_strb), 32'h0);
    check("lb_err", 32'(last_err), 32'h0);

    run_tx("lhu", 1, 0, 0, 32'h8000_0002, 3'b101, 32'h0, 32'h9234_5678, 0, 0, 0);
    check("lhu_rdata", last_rdata, 32'h0000_9234);
    run_tx("lh", 1, 0, 0, 32'h8000_0002, 3'b001, 32'h0, 32'h9234_5678, 0, 0, 0);
    check("lh_rdata", last_rdata, 32'hFFFF_9234);
    run_tx("lbu1", 1, 0, 0, 32'h8000_0005, 3'b100, 32'h0, 32'h1234_5678, 0, 0, 0);
    check("lbu1_rdata", last_rdata, 32'h0000_0056);
    run_tx("lb2", 1, 0, 0, 32'h8000_0006, 3'b000, 32'h0, 32'h00F0_0000, 0, 0, 0);
    check("lb2_rdata", last_rdata, 32'hFFFF_FFF0);

    run_tx("sb", 0, 1, 0, 32'h8000_0001, 3'b000, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 0, 0);
    check("sb_wen", 32'(last_mwen), 32'h1);
    check("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    check("sb_strb", 32'(last_strb), 32'h2);
    check("sb_rdata", last_rdata, 32'h0);

    run_tx("sh2", 0, 1, 0, 32'h8000_0012, 3'b001, 32'h0000_BEEF, 32'h0, 0, 0, 0);
    check("sh2_wdata", last_wdata, 32'hBEEF_BEEF);
    check("sh2_strb", 32'(last_strb), 32'hC);

    run_tx("bp_sw", 0, 1, 0, 32'h8000_0010, 3'b010, 32'hDEAD_BEEF, 32'h0, 0, 5, 4);
    check("bp_sw_wdata", last_wdata, 32'hDEAD_BEEF);
    check("bp_sw_strb", 32'(last_strb), 32'hF);

    run_tx("fencei", 0, 0, 1, 32'h8000_0000, 3'b010, 32'h0, 32'h1111_1111, 0, 0, 0);
    check("fencei_rdata", last_rdata, 32'h0);
    check("fencei_nobus", last_maddr, SENT);
    run_tx("noop", 0, 0, 0, 32'h8000_0004, 3'b010, 32'h0, 32'h2222_2222, 0, 0, 2);
    check("noop_rdata", last_rdata, 32'h0);

    run_tx("lw_err", 1, 0, 0, 32'h8000_0020, 3'b010, 32'h0, 32'h1122_3344, 1, 0, 0);
    check("lw_err_err", 32'(last_err), 32'h1);
    check("lw_err_rdata", last_rdata, 32'h1122_3344);
    run_tx("lw_sz3", 1, 0, 0, 32'h8000_0024, 3'b011, 32'h0, 32'hCAFE_BABE, 0, 0, 0);
    check("lw_sz3_rdata", last_rdata, 32'hCAFE_BABE);

    run_tx("sh3", 0, 1, 0, 32'h8000_0033, 3'b001, 32'h0000_BEEF, 32'h0, 0, 0, 0);
    run_tx("lh3", 1, 0, 0, 32'h8000_0033, 3'b001, 32'h0, 32'hAABB_CCDD, 0, 0, 0);
`ifdef LIEAT_LSU_MISALIGN_CHK_EN
    check("lh3_rdata", last_rdata, 32'h0);
    check("lh3_err", 32'(last_err), 32'h1);
`else
    check("lh3_rdata", last_rdata, 32'h0000_00AA);
    check("lh3_err", 32'(last_err), 32'h0);
`endif
    run_tx("lw2", 1, 0, 0, 32'h8000_0002, 3'b010, 32'h0, 32'h1357_2468, 0, 0, 0);
`ifdef LIEAT_LSU_MISALIGN_CHK_EN
    check("lw2_err", 32'(last_err), 32'h1);
    check("lw2_nobus", last_maddr, SENT);
`else
    check("lw2_rdata", last_rdata, 32'h1357_2468);
    check("lw2_addr", last_maddr, 32'h8000_0000);
`endif

    // reset while waiting for the bus response
    mon_en = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.lsu_req_ren = 1'b1; bus.lsu_req_wen = 1'b0;
    bus.lsu_req_fencei = 1'b0; bus.lsu_req_addr = 32'h8000_0040; bus.lsu_req_flag = 3'b010;
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0; bus.lsu_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.lsu_req_valid = 1'b0;
    @(negedge clk);
    check("mid_req_valid", 32'(bus.mem_req_valid), 32'h1);
    @(negedge clk);
    check("mid_wait_ready", 32'(bus.mem_rsp_ready), 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_rsp_ready", 32'(bus.mem_rsp_ready), 32'h0);
    check("mid_rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    check("mid_rst_rsp_valid", 32'(bus.lsu_rsp_valid), 32'h0);
    check("mid_rst_req_ready", 32'(bus.lsu_req_ready), 32'h1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    bus.lsu_rsp_ready = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.lsu_req_ready), 32'h1);
    check("post_rst_rsp_valid", 32'(bus.lsu_rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    run_tx("post_lw", 1, 0, 0, 32'h8000_0044, 3'b010, 32'h0, 32'h0BAD_F00D, 0, 0, 0);
    check("post_lw_rdata", last_rdata, 32'h0BAD_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
